// File: rtl/btc_pkg.sv
// rtl/btc_pkg.sv - shared widths, FSM encoding and INT16 clamp bounds for the psum/requant block.
package btc_pkg;

  localparam int LANES  = 16;
  localparam int ACC_W  = 32;
  localparam int OUT_W  = 16;
  localparam int KCNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_REQ,
    ST_DRAIN
  } state_e;

  // Bounds carried at ACC_W+1 bits so they compare directly against the rounded value.
  localparam logic signed [ACC_W:0] INT16_MAX = 33'sd32767;
  localparam logic signed [ACC_W:0] INT16_MIN = -33'sd32768;

endpackage

// File: rtl/btc_lane_requant.sv
// rtl/btc_lane_requant.sv - one lane of rounding right shift, optional ReLU and INT16 saturation.
module btc_lane_requant
  import btc_pkg::*;
(
  input  logic [ACC_W-1:0] x,
  input  logic [4:0]       shift,
  input  logic             relu,
  output logic [OUT_W-1:0] y,
  output logic             sat
);

  logic signed [ACC_W:0] ext;
  logic signed [ACC_W:0] half;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] shf;

  always_comb begin
    ext  = $signed({x[ACC_W-1], x});
    half = '0;
    rnd  = ext;
    shf  = ext;
    sat  = 1'b0;
    y    = '0;
    // One extra bit of headroom keeps x + 2^(s-1) from wrapping near INT32_MAX.
    if (shift != 5'd0) begin
      half = {{ACC_W{1'b0}}, 1'b1} << (shift - 5'd1);
      rnd  = ext + half;
      shf  = rnd >>> shift;
    end
    if (relu && shf[ACC_W]) begin
      shf = '0;
    end
    if (shf > INT16_MAX) begin
      y   = INT16_MAX[OUT_W-1:0];
      sat = 1'b1;
    end else if (shf < INT16_MIN) begin
      y   = INT16_MIN[OUT_W-1:0];
      sat = 1'b1;
    end else begin
      y = shf[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/btc_psum_requant.sv
// rtl/btc_psum_requant.sv - K-tile partial-sum feedback register with requantizing valid/ready output.
module btc_psum_requant
  import btc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [KCNT_W-1:0]        tile_count,
  input  logic [4:0]               cfg_shift,
  input  logic                     cfg_relu,
  input  logic [LANES*ACC_W-1:0]   result_in,
  input  logic                     result_valid,
  output logic [LANES*ACC_W-1:0]   psum_out,
  output logic                     psum_update,
  output logic [LANES*OUT_W-1:0]   out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     sat_flag
);

  state_e                   state_q, state_d;
  logic [KCNT_W-1:0]        kcnt_q, kcnt_d;
  logic [KCNT_W-1:0]        tcnt_q, tcnt_d;
  logic [4:0]               shift_q, shift_d;
  logic                     relu_q, relu_d;
  logic [LANES*ACC_W-1:0]   psum_q, psum_d;
  logic                     psum_update_q, psum_update_d;
  logic [LANES*OUT_W-1:0]   out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     sat_q, sat_d;

  logic [LANES*OUT_W-1:0]   lane_y;
  logic [LANES-1:0]         lane_sat;
  logic [KCNT_W-1:0]        kcnt_inc;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    btc_lane_requant u_lane (
      .x     (psum_q[ACC_W*i +: ACC_W]),
      .shift (shift_q),
      .relu  (relu_q),
      .y     (lane_y[OUT_W*i +: OUT_W]),
      .sat   (lane_sat[i])
    );
  end

  // tile_count never exceeds the counter range, so the increment cannot wrap.
  assign kcnt_inc = kcnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    kcnt_d        = kcnt_q;
    tcnt_d        = tcnt_q;
    shift_d       = shift_q;
    relu_d        = relu_q;
    psum_d        = psum_q;
    psum_update_d = 1'b0;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    sat_d         = sat_q;
    case (state_q)
      ST_IDLE: begin
        if (start && (tile_count != '0)) begin
          tcnt_d        = tile_count;
          shift_d       = cfg_shift;
          relu_d        = cfg_relu;
          psum_d        = '0;
          kcnt_d        = '0;
          psum_update_d = 1'b1;
          sat_d         = 1'b0;
          state_d       = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (result_valid) begin
          psum_d = result_in;
          kcnt_d = kcnt_inc;
          if (kcnt_inc < tcnt_q) begin
            psum_update_d = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        out_data_d  = lane_y;
        out_valid_d = 1'b1;
        sat_d       = sat_q | (|lane_sat);
        state_d     = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      kcnt_q        <= '0;
      tcnt_q        <= '0;
      shift_q       <= '0;
      relu_q        <= 1'b0;
      psum_q        <= '0;
      psum_update_q <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      sat_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      kcnt_q        <= kcnt_d;
      tcnt_q        <= tcnt_d;
      shift_q       <= shift_d;
      relu_q        <= relu_d;
      psum_q        <= psum_d;
      psum_update_q <= psum_update_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      sat_q         <= sat_d;
    end
  end

  assign psum_out    = psum_q;
  assign psum_update = psum_update_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign busy        = (state_q != ST_IDLE);
  assign sat_flag    = sat_q;

endmodule
